// File: rtl/adder_ins_packer.sv
// adder_ins_packer: collects a stream of W-bit operands over valid/ready and
// packs them into the 4*W operand bus of the 4-operand adder
// ({w,z,y,x}, x in the low W bits), along with a carry-in and a fill count.
// A group closes on its 4th word or early on in_last; unused slots are zero.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_data[W-1:0]     operand word
//   in_cin             carry-in, sampled on the group-closing word
//   in_last            close the group early (remaining slots zero)
//   in_valid/in_ready  input handshake (in_ready depends on state only)
//   out_ins[4W-1:0]    packed operands {w,z,y,x}
//   out_cin            carry-in for the group
//   out_fill[2:0]      number of real words in the group, 1..4
//   out_valid/out_ready output handshake (out_valid is registered state)
//
// Build option: ADDER_INS_PACKER_DBUF_EN adds an output register behind the
// assembly slots so a new group can be collected while the previous one
// waits for the adder (one word per cycle sustained). Undefined: a single
// buffer alternating between COLLECT and HOLD.

// One operand slot. Clear wins over write so a group can leave the slots in
// the same cycle its last word arrives.
module adder_ins_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (wr)  q <= din;
endmodule

module adder_ins_packer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic           in_cin,
  input  logic           in_last,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [4*W-1:0] out_ins,
  output logic           out_cin,
  output logic [2:0]     out_fill,
  output logic           out_valid,
  input  logic           out_ready
);
  localparam int NUM_LANES = 4;

  // COLLECT: assembly slots accept words.
  // HOLD:    a closed group owns the assembly slots (single buffer: it is
  //          being presented; double buffer: it waits for the output reg).
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic [1:0]                  idx;
  logic [NUM_LANES-1:0][W-1:0] slot_q;
  logic [NUM_LANES-1:0]        slot_wr;
  logic                        slot_clr;
  logic                        in_acc, close;
  logic                        grp_cin;
  logic [2:0]                  grp_fill, cls_fill;

  assign in_ready = (state == COLLECT);
  assign in_acc   = in_valid && in_ready;
  assign close    = in_acc && ((idx == 2'd3) || in_last);
  assign cls_fill = {1'b0, idx} + 3'd1;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign slot_wr[g] = in_acc && (idx == 2'(g));
    adder_ins_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (slot_wr[g]),
      .clr   (slot_clr),
      .din   (in_data),
      .q     (slot_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;

  // Slot index restarts on every close, so the next group always begins at x.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      idx <= '0;
    else if (close)  idx <= '0;
    else if (in_acc) idx <= idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grp_cin  <= 1'b0;
      grp_fill <= '0;
    end else if (close) begin
      grp_cin  <= in_cin;
      grp_fill <= cls_fill;
    end

`ifdef ADDER_INS_PACKER_DBUF_EN
  logic                        out_vq, out_free, xfer;
  logic [NUM_LANES-1:0][W-1:0] merged;
  logic [4*W-1:0]              ins_q;
  logic                        cin_q;
  logic [2:0]                  fill_q;

  // Slot contents including the word being written this cycle, so a group
  // can move to the output register in the same cycle it closes.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_merge
    assign merged[g] = slot_wr[g] ? in_data : slot_q[g];
  end

  assign out_free  = !out_vq || out_ready;
  assign out_valid = out_vq;

  always_comb begin
    state_nxt = state;
    slot_clr  = 1'b0;
    xfer      = 1'b0;
    case (state)
      COLLECT:
        if (close) begin
          if (out_free) begin
            xfer     = 1'b1;
            slot_clr = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end
      HOLD:
        if (out_free) begin
          xfer      = 1'b1;
          slot_clr  = 1'b1;
          state_nxt = COLLECT;
        end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_vq <= 1'b0;
      ins_q  <= '0;
      cin_q  <= 1'b0;
      fill_q <= '0;
    end else if (xfer) begin
      out_vq <= 1'b1;
      ins_q  <= merged;
      // Closing word's sideband is live in COLLECT; a parked group uses the
      // copy captured when it closed.
      cin_q  <= (state == COLLECT) ? in_cin   : grp_cin;
      fill_q <= (state == COLLECT) ? cls_fill : grp_fill;
    end else if (out_ready) begin
      out_vq <= 1'b0;
    end

  assign out_ins  = ins_q;
  assign out_cin  = cin_q;
  assign out_fill = fill_q;
`else
  assign out_valid = (state == HOLD);

  always_comb begin
    state_nxt = state;
    slot_clr  = 1'b0;
    case (state)
      COLLECT:
        if (close) state_nxt = HOLD;
      HOLD:
        if (out_ready) begin
          state_nxt = COLLECT;
          slot_clr  = 1'b1;
        end
    endcase
  end

  // The slots themselves are the output bus; they only change in COLLECT.
  assign out_ins  = slot_q;
  assign out_cin  = grp_cin;
  assign out_fill = grp_fill;
`endif

endmodule

// File: tb/tb_adder_ins_packer.sv
// Bench for adder_ins_packer: a queue-based model of closed groups awaiting
// the adder, compared against the DUT every cycle, plus directed scenarios
// with hand-computed expectations and a randomized stream.
module tb_adder_ins_packer;
  localparam int W = 8;
`ifdef ADDER_INS_PACKER_DBUF_EN
  localparam int CAP   = 2;   // groups the packer can hold (assembly + output)
  localparam bit T1RDY = 1'b1;
  localparam int T3ACC = 4;
`else
  localparam int CAP   = 1;
  localparam bit T1RDY = 1'b0;
  localparam int T3ACC = 0;
`endif

  logic           clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_cin = 1'b0, in_last = 1'b0, in_valid = 1'b0;
  logic           in_ready;
  logic [4*W-1:0] out_ins;
  logic           out_cin;
  logic [2:0]     out_fill;
  logic           out_valid;
  logic           out_ready = 1'b0;

  adder_ins_packer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cin(in_cin),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_ins(out_ins), .out_cin(out_cin), .out_fill(out_fill),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*W-1:0] ins;
    logic           cin;
    logic [2:0]     fill;
  } grp_t;

  grp_t         pend[$];     // closed groups not yet taken by the adder
  logic [W-1:0] cur[4];      // words of the group being collected
  int           n = 0;
  int           checks = 0, errors = 0;
  int           closed = 0, delivered = 0;
  bit           acc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    bit ev;
    ev = pend.size() > 0;
    chk("in_ready", 32'(in_ready), 32'(pend.size() < CAP));
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (!rst_n) begin
      chk("rst_ins", out_ins, 32'h0);
      chk("rst_cin", 32'(out_cin), 32'h0);
      chk("rst_fill", 32'(out_fill), 32'h0);
    end else if (ev) begin
      chk("out_ins", out_ins, pend[0].ins);
      chk("out_cin", 32'(out_cin), 32'(pend[0].cin));
      chk("out_fill", 32'(out_fill), 32'(pend[0].fill));
    end
  endtask

  task automatic update();
    bit rdy, vld;
    grp_t g;
    rdy = pend.size() < CAP;
    vld = pend.size() > 0;
    acc = 1'b0;
    if (!rst_n) begin
      pend.delete();
      n = 0;
      return;
    end
    if (vld && out_ready) begin
      void'(pend.pop_front());
      delivered++;
    end
    if (in_valid && rdy) begin
      acc    = 1'b1;
      cur[n] = in_data;
      n++;
      if (n == 4 || in_last) begin
        g.ins = '0;
        for (int i = 0; i < n; i++) g.ins[i*W +: W] = cur[i];
        g.cin  = in_cin;
        g.fill = 3'(n);
        pend.push_back(g);
        closed++;
        n = 0;
      end
    end
  endtask

  // One clock: check outputs on the falling edge, advance the model on the
  // rising edge, then return just after it so inputs change away from edges.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic c, input logic l);
    in_valid = 1'b1; in_data = d; in_cin = c; in_last = l;
    step();
    in_valid = 1'b0; in_last = 1'b0; in_cin = 1'b0;
  endtask

  initial begin
    int k, d0, c0, cyc;
    logic [W-1:0] rd;
    logic rc, rl;

    // Reset state
    step(); step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // 4 words back to back, cin on the last
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b1, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_ins", out_ins, 32'h04030201);
    chk("t1_cin", 32'(out_cin), 32'h1);
    chk("t1_fill", 32'(out_fill), 32'h4);
    chk("t1_in_ready", 32'(in_ready), 32'(T1RDY));
    step();
    chk("t1_valid_drop", 32'(out_valid), 32'h0);

    // Early close after two words
    send(8'hAA, 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b1);
    chk("t2_ins", out_ins, 32'h000055AA);
    chk("t2_fill", 32'(out_fill), 32'h2);
    chk("t2_cin", 32'(out_cin), 32'h1);
    step();

    // Backpressure for 10 cycles with in_valid held high
    out_ready = 1'b0;
    send(8'h11, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    send(8'h13, 1'b0, 1'b0);
    send(8'h14, 1'b0, 1'b0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h21 + k);
      step();
      if (acc) k++;
      chk("t3_valid", 32'(out_valid), 32'h1);
      chk("t3_ins", out_ins, 32'h14131211);
    end
    chk("t3_accepted", k, T3ACC);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
`ifdef ADDER_INS_PACKER_DBUF_EN
    chk("t3_second_ins", out_ins, 32'h24232221);
    chk("t3_second_valid", 32'(out_valid), 32'h1);
`else
    chk("t3_release_valid", 32'(out_valid), 32'h0);
`endif
    step(); step();

    // Reset mid-group
    send(8'h51, 1'b0, 1'b0);
    send(8'h52, 1'b0, 1'b0);
    send(8'h53, 1'b0, 1'b0);
    rst_n = 1'b0;
    pend.delete();
    n = 0;
    #1;
    chk("t4_valid", 32'(out_valid), 32'h0);
    chk("t4_ins", out_ins, 32'h0);
    step(); step();
    rst_n = 1'b1;
    send(8'h31, 1'b0, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    chk("t4_fresh_ins", out_ins, 32'h34333231);
    chk("t4_fresh_fill", 32'(out_fill), 32'h4);
    step();

    // in_last on the first word, then the next group starts at x
    send(8'hFF, 1'b0, 1'b1);
    chk("t5_ins", out_ins, 32'h000000FF);
    chk("t5_fill", 32'(out_fill), 32'h1);
    chk("t5_cin", 32'(out_cin), 32'h0);
    step();
    send(8'h41, 1'b0, 1'b0);
    send(8'h42, 1'b1, 1'b1);
    chk("t5_next_ins", out_ins, 32'h00004241);
    chk("t5_next_fill", 32'(out_fill), 32'h2);
    step();

    // Random stream of 100 groups with gaps on both sides
    c0 = closed; d0 = delivered; cyc = 0;
    rd = 8'($urandom); rc = 1'($urandom); rl = ($urandom_range(0, 3) == 0);
    while (cyc < 20000 && !((closed - c0 >= 100) && pend.size() == 0)) begin
      in_valid  = (closed - c0 < 100) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = rd; in_cin = rc; in_last = rl;
      step();
      cyc++;
      if (acc) begin
        rd = 8'($urandom); rc = 1'($urandom); rl = ($urandom_range(0, 3) == 0);
      end
    end
    in_valid = 1'b0;
    if (cyc >= 20000) begin
      checks++;
      errors++;
      $display("FAIL t6_timeout got %0d groups want 100", closed - c0);
    end
    chk("t6_delivered", delivered - d0, closed - c0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_ins_packer.md
Name: adder_ins_packer

Overview:
- Source-side companion of the 4-operand adder.
- Collects a stream of W-bit operands over a valid/ready handshake and packs them into the 4*W operand bus: x in [W-1:0], y in [2W-1:W], z in [3W-1:2W], w in [4W-1:3W].
- Presents the packed bus plus a carry-in to the adder with a valid/ready handshake.
- Supports early group close (in_last) with zero padding, so partial sums are possible.

Parameters:
W  8  operand width; packed bus width is 4*W

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
in_data  input  W  operand word
in_cin  input  1  carry-in; meaningful only on the group-closing word
in_last  input  1  closes the current group early; remaining slots are zero
in_valid  input  1  upstream word valid
in_ready  output  1  packer can accept a word this cycle
out_ins  output  4*W  packed operands {w,z,y,x}
out_cin  output  1  carry-in for the packed group
out_fill  output  3  number of real words in group, 1..4
out_valid  output  1  packed group valid
out_ready  input  1  adder side accepts the group

Behaviour:
- Reset values:
  - out_valid=0, out_ins=0, out_cin=0, out_fill=0.
  - Slot index=0, state COLLECT; in_ready=1 after reset.
- Input handshake: a word is accepted when in_valid && in_ready.
- Output handshake: a group is accepted when out_valid && out_ready.
- Assembly:
  - An accepted word is written into slot idx (0=x, 1=y, 2=z, 3=w), and idx increments.
  - At group start all slots are 0.
  - The group closes on an accepted word when idx==3 or in_last=1.
  - in_cin and the fill count (idx+1) are captured on the closing word.
  - in_last on the 4th word is equivalent to a normal close.
  - in_last=1 on the first word gives out_fill=1 with y, z and w all zero.
- States:
  - COLLECT: in_ready=1; out_valid=0. On the closing handshake, go to HOLD next cycle.
  - HOLD: in_ready=0; out_valid=1; out_ins, out_cin and out_fill are stable. On the output handshake, go to COLLECT next cycle with idx=0 and slots cleared.
- Latency and throughput:
  - out_valid rises on the cycle after the closing input handshake.
  - With out_ready held high: 4 words plus 1 hold cycle, i.e. one group per 5 cycles.
- Backpressure:
  - While out_ready=0, the outputs are held indefinitely.
  - in_valid during HOLD is ignored; no word is lost because in_ready=0.
- in_valid=0 mid-group: no progress, and the partial group is retained.
- Asynchronous reset mid-group or mid-HOLD discards all data and returns to the reset values immediately.
- in_ready is a combinational function of state only; it never depends on in_valid.
- out_valid never depends combinationally on out_ready.

Optional Feature:
- Macro: ADDER_INS_PACKER_DBUF_EN.
- Defined:
  - Separate assembly register and output register.
  - A closed group transfers to the output register in the same cycle it closes if the output register is empty or is being accepted that cycle. Otherwise it waits in assembly, and in_ready=0 until the transfer.
  - in_ready is still driven from registered state plus out_ready only.
  - out_valid rises one cycle after the close.
  - With out_ready high, throughput is one word per cycle: one group every 4 cycles, with no bubble.
- Undefined: the single-buffer COLLECT/HOLD behaviour above.
- Both builds share the same ports and the same reset values.

Test Plan:
- Send 4 words 0x01, 0x02, 0x03, 0x04 back-to-back, cin=1 on the 4th word, out_ready=1 -> one cycle after the 4th word: out_ins=0x04030201, out_cin=1, out_fill=4, out_valid for 1 cycle. in_ready is low for 1 cycle (DBUF_EN: never low).
- Send 2 words 0xAA, 0x55 with in_last on the 2nd -> out_ins=0x000055AA, out_fill=2, out_cin equal to in_cin of the 2nd word.
- Close a group with out_ready=0 for 10 cycles while in_valid stays high -> out_* stable and out_valid high throughout. Non-DBUF: in_ready=0 and no word is accepted. DBUF: exactly 4 more words are accepted, then in_ready=0. Releasing out_ready delivers both groups in order.
- Assert rst_n low after 3 words, then release -> out_valid=0 and out_ins=0. The next 4 words form a fresh group with no residue from before the reset.
- in_last on the first word 0xFF with cin=0 -> out_ins=0x000000FF, out_fill=1. The following group starts at slot x.
- Stream 100 random groups with random in_valid/out_ready gaps and random in_last -> every output group equals the scoreboard packing, with no drop and no duplicate.
